spi_mnrch: RTL
==============

SPI_MNRCH -- requirements
Module: spi_mnrch

Interface
REQ-001 SCLK_W, default 5, width of the SCLK divider counter; the SCLK period is 2^SCLK_W clk cycles. All cycle numbers below assume the default.
REQ-002 clk  input  1  system clock; all flops rise-edge triggered.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wrt  input  1  one-cycle pulse that starts a 16-bit transaction; honoured only in IDLE.
REQ-005 wt_data  input  16  word to shift out on MOSI, MSB first; sampled on the wrt cycle.
REQ-006 done  output  1  set when a transaction completes, cleared by the next accepted wrt.
REQ-007 rd_data  output  16  word received on MISO, MSB first; valid while done=1.
REQ-008 SS_n  output  1  active-low serf select.
REQ-009 SCLK  output  1  serial clock; idle high.
REQ-010 MOSI  output  1  serial data to the serf; equals shft_reg[15].
REQ-011 MISO  input  1  serial data from the serf.

Function
REQ-012 The block shall be the master side of the 16-bit SPI link used by the team's A2D serf: the serf samples MOSI on SCLK rise, ignores the first SCLK fall, and shifts MISO on each later fall.
REQ-013 Divider sclk_div[4:0] shall increment every cycle while not IDLE; SCLK shall be sclk_div[4] straight from a flop (glitch-free); in IDLE sclk_div shall be held at 5'b10111.
REQ-014 One 16-bit shft_reg shall serve both directions: on shift, shft_reg <= {shft_reg[14:0], miso_smpl}; MOSI = shft_reg[15]; rd_data = shft_reg.
REQ-015 States shall be IDLE, FRONT_PORCH, SHIFTING and BACK_PORCH.
REQ-016 IDLE: on wrt, load shft_reg <= wt_data, clear done, set SS_n <= 0, and go to FRONT_PORCH.
REQ-017 FRONT_PORCH: at sclk_div==5'b11111, go to SHIFTING with no shift; the resulting SCLK fall is the serf's skipped fall.
REQ-018 SHIFTING: at sclk_div==5'b01111 (cycle before SCLK rise), capture miso_smpl <= MISO; at sclk_div==5'b11111 (cycle before SCLK fall), shift and increment bit_cnt[4:0].
REQ-019 When bit_cnt reaches 15 (15 shifts done) and the 16th MISO sample has been taken, go to BACK_PORCH.
REQ-020 BACK_PORCH: at sclk_div==5'b11111, perform the 16th shift, set done, set SS_n <= 1, reload sclk_div <= 5'b10111 so SCLK never falls, and go to IDLE.
REQ-021 Timing (wrt at cycle T0):
  - T1: SS_n=0, SCLK=1.
  - T10: first SCLK fall.
  - T25 + 32k (k=0..15): MISO sample k.
  - T26 + 32k: SCLK rises.
  - T521: 16th shift.
  - T522: done=1, SS_n=1.
  - A transaction shall take exactly 522 cycles.
REQ-022 wrt while not IDLE shall be ignored; shft_reg, bit_cnt and timing shall be unaffected.
REQ-023 wrt in the same cycle that done would be set shall be ignored; wrt one cycle later shall be accepted and shall clear done.
REQ-024 bit_cnt shall clear on every accepted wrt; sclk_div shall never wrap inside BACK_PORCH.
REQ-025 done and rd_data shall hold their values in IDLE until the next accepted wrt.

Reset
REQ-026 rst shall asynchronously force: state=IDLE, SS_n=1, SCLK=1 (sclk_div=5'b10111), done=0, shft_reg=16'h0000, bit_cnt=0, miso_smpl=0.
REQ-027 rst asserted mid-transaction shall abort it with no partial done; the first wrt after rst deasserts shall start a full 522-cycle transaction.

Verification
REQ-028 Loopback MOSI->MISO, wrt with wt_data=16'hA5C3 -> done rises at T522, rd_data=16'hA5C3, 16 SCLK rises observed, SS_n low T1..T521.
REQ-029 Against the A2D serf model with A2D_data=16'h0C00, wt_data=16'h2800 -> serf cmd=16'h2800 and its rdy set; on the second transaction rd_data=16'h0C00.
REQ-030 wrt pulsed at T100 and T300 of an active transaction -> ignored; rd_data and completion cycle identical to the undisturbed run.
REQ-031 rst pulsed at T200 -> SS_n=1, SCLK=1, done=0 immediately; a new wrt with 16'h1234 in loopback -> rd_data=16'h1234 at T522.
REQ-032 Back-to-back runs, wrt one cycle after done with 16'hFFFF then 16'h0001 (loopback) -> done cleared on the wrt cycle, both words returned, SCLK high between transactions, no extra SCLK edges.

Source files
------------

// File: rtl/spi_mnrch.sv
// rtl/spi_mnrch.sv - 16-bit SPI master for the A2D serf link
module spi_mnrch #(
    parameter int SCLK_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    // Idle value keeps SCLK high and lands the first fall a short porch after SS_n drops.
    localparam logic [SCLK_W-1:0] DIV_IDLE = {2'b10, {(SCLK_W-2){1'b1}}};
    // Divider value on the cycle before SCLK falls.
    localparam logic [SCLK_W-1:0] DIV_FALL = {SCLK_W{1'b1}};
    // Divider value on the cycle before SCLK rises.
    localparam logic [SCLK_W-1:0] DIV_RISE = {1'b0, {(SCLK_W-1){1'b1}}};
    localparam logic [SCLK_W-1:0] DIV_ONE  = {{(SCLK_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        FRONT_PORCH,
        SHIFTING,
        BACK_PORCH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SCLK_W-1:0] sclk_div;
    logic [15:0]       shft_reg;
    logic [4:0]        bit_cnt;
    logic              miso_smpl;

    logic              load;
    logic              capture;
    logic              shift;
    logic              finish;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes, decoded from the divider phase.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        capture   = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (wrt) begin
                    load      = 1'b1;
                    state_nxt = FRONT_PORCH;
                end
            end
            FRONT_PORCH: begin
                // The fall that follows is the one the serf ignores: no shift here.
                if (sclk_div == DIV_FALL) begin
                    state_nxt = SHIFTING;
                end
            end
            SHIFTING: begin
                if (sclk_div == DIV_RISE) begin
                    capture = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        state_nxt = BACK_PORCH;
                    end
                end else if (sclk_div == DIV_FALL) begin
                    shift = 1'b1;
                end
            end
            BACK_PORCH: begin
                if (sclk_div == DIV_FALL) begin
                    shift     = 1'b1;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // SCLK divider: free-runs during a transaction, parked high otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_div <= DIV_IDLE;
        end else if (finish || state == IDLE) begin
            sclk_div <= DIV_IDLE;
        end else begin
            sclk_div <= sclk_div + DIV_ONE;
        end
    end

    // Shared shift register, MISO sample flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shft_reg  <= 16'h0000;
            miso_smpl <= 1'b0;
            bit_cnt   <= 5'd0;
        end else begin
            if (load) begin
                shft_reg <= wt_data;
                bit_cnt  <= 5'd0;
            end else if (shift) begin
                shft_reg <= {shft_reg[14:0], miso_smpl};
                bit_cnt  <= bit_cnt + 5'd1;
            end
            if (capture) begin
                miso_smpl <= MISO;
            end
        end
    end

    // Completion flag and serf select, both registered for glitch-free outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            SS_n <= 1'b1;
        end else if (load) begin
            done <= 1'b0;
            SS_n <= 1'b0;
        end else if (finish) begin
            done <= 1'b1;
            SS_n <= 1'b1;
        end
    end

    assign SCLK    = sclk_div[SCLK_W-1];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

endmodule
